// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, fetch entry layout and helpers.
package cpu_pkg;

    localparam int XLEN = 32;

    // Instruction word returned for fetches that never reach memory.
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic            err;
    } fetch_entry_t;

    // Instruction fetches must be word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; pointers wrap modulo DEPTH.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Flush wins over both push and pop; a push into a full FIFO is only taken alongside a pop.
    assign wr_en_s = push_i && (!full_o || pop_i) && !flush_i;
    assign rd_en_s = pop_i && !empty_o && !flush_i;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(wr_en_s) - CNT_W'(rd_en_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as all zeros.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: takes addresses from the PC, issues one outstanding memory read,
// and queues {addr, data, err} entries for decode. Supports redirect flush.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = XLEN,
    parameter int DATA_W     = XLEN,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_err,
    input  logic              instr_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              push_s;
    logic              pop_s;
    fetch_entry_t      push_entry_s;
    fetch_entry_t      head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              reserved_s;
    logic [CNT_W:0]    occupancy_s;
    logic              slot_free_s;
    logic              pc_ready_s;
    logic              pc_xfer_s;

    // A fetch between PC acceptance and its response owns a FIFO slot, so the
    // eventual push can never find the FIFO full.
    assign reserved_s  = (state_q == REQ) || (state_q == WAIT);
    assign occupancy_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, reserved_s};
    assign slot_free_s = !fifo_full_s && (occupancy_s < (CNT_W+1)'(FIFO_DEPTH));

    // Readiness depends only on registered state, flush and reset; a pop frees
    // a slot for the PC from the following cycle.
    assign pc_ready_s = reset && (state_q == IDLE) && slot_free_s && !flush;
    assign pc_xfer_s  = pc_valid && pc_ready_s;
    assign pop_s      = instr_ready && !fifo_empty_s;

    assign pc_ready      = pc_ready_s;
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = addr_q;
    assign instr_valid   = !fifo_empty_s;
    assign instr_data    = head_s.data;
    assign instr_addr    = head_s.addr;
    assign instr_err     = head_s.err;

    // Next-state logic and FIFO push generation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        push_s       = 1'b0;
        push_entry_s = '0;
        case (state_q)
            IDLE: begin
                if (pc_xfer_s) begin
                    if (is_misaligned(pc_addr)) begin
                        push_s            = 1'b1;
                        push_entry_s.addr = pc_addr;
                        push_entry_s.data = NOP;
                        push_entry_s.err  = 1'b1;
                    end else begin
                        addr_d  = pc_addr;
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (flush) begin
                    // An accepted request still owes a response that must be dropped.
                    state_d = mem_req_ready ? DRAIN : IDLE;
                end else if (mem_req_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = mem_resp_valid ? IDLE : DRAIN;
                end else if (mem_resp_valid) begin
                    push_s            = 1'b1;
                    push_entry_s.addr = addr_q;
                    push_entry_s.data = mem_resp_data;
                    push_entry_s.err  = 1'b0;
                    state_d           = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and latched fetch address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .flush_i     (flush),
        .head_o      (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random traffic, all
// checked against a transaction-level model (queue of decode entries plus the
// status of the single fetch in progress).
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_addr;
    logic        instr_err;
    logic        instr_ready;

    instr_fetch #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_addr        (pc_addr),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_addr     (instr_addr),
        .instr_err      (instr_err),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
    } ent_t;

    // Reference model state.
    ent_t        mq[$];      // entries visible to decode, head first
    logic        m_busy;     // an accepted PC address is being fetched
    logic        m_acc;      // ...and memory has accepted its request
    logic [31:0] m_addr;
    logic        m_drain;    // a cancelled request still owes a response
    logic        last_xfer;

    // Behavioural memory.
    logic        auto_mem;
    logic        mem_pend;
    int          mem_wait;
    logic [31:0] mem_dat;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_pc_ready();
        return !m_busy && !m_drain && (mq.size() < 2) && !flush;
    endfunction

    // Advance the model by one clock edge using the inputs of this cycle.
    task automatic model_update();
        logic pr, pop, macc, resp;
        ent_t en;
        pr        = exp_pc_ready();
        pop       = instr_ready && (mq.size() != 0);
        macc      = m_busy && !m_acc && mem_req_ready;
        resp      = mem_resp_valid;
        last_xfer = pc_valid && pr;
        if (auto_mem) begin
            if (resp) mem_pend = 1'b0;
            if (macc) begin
                mem_pend = 1'b1;
                mem_wait = $urandom_range(4, 1);
                mem_dat  = $urandom;
            end
        end
        if (flush) begin
            mq.delete();
            if (m_busy) begin
                m_drain = m_acc ? !resp : macc;
                m_busy  = 1'b0;
            end else if (m_drain && resp) begin
                m_drain = 1'b0;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_drain) begin
                if (resp) m_drain = 1'b0;
            end else if (m_busy) begin
                if (!m_acc) begin
                    if (macc) m_acc = 1'b1;
                end else if (resp) begin
                    en.a = m_addr; en.d = mem_resp_data; en.e = 1'b0;
                    mq.push_back(en);
                    m_busy = 1'b0;
                end
            end else if (last_xfer) begin
                if (pc_addr[1:0] != 2'b00) begin
                    en.a = pc_addr; en.d = 32'h0; en.e = 1'b1;
                    mq.push_back(en);
                end else begin
                    m_busy = 1'b1;
                    m_acc  = 1'b0;
                    m_addr = pc_addr;
                end
            end
        end
    endtask

    task automatic drive_mem();
        if (mem_pend) begin
            if (mem_wait > 0) mem_wait--;
            mem_resp_valid = (mem_wait == 0);
            mem_resp_data  = mem_dat;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
        end
    endtask

    // One clock: compare outputs with the model, take the edge, return at negedge.
    task automatic cycle();
        #1;
        check("pc_ready", pc_ready, exp_pc_ready());
        check("mem_req_valid", mem_req_valid, m_busy && !m_acc);
        if (m_busy && !m_acc) check("mem_req_addr", mem_req_addr, m_addr);
        check("instr_valid", instr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("instr_addr", instr_addr, mq[0].a);
            check("instr_data", instr_data, mq[0].d);
            check("instr_err", instr_err, mq[0].e);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (auto_mem) drive_mem();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        check("rst_pc_ready", pc_ready, 1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_req_addr", mem_req_addr, 32'h0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr_data", instr_data, 32'h0);
        check("rst_instr_addr", instr_addr, 32'h0);
        check("rst_instr_err", instr_err, 1'b0);
        mq.delete();
        m_busy = 1'b0; m_acc = 1'b0; m_drain = 1'b0;
        mem_pend = 1'b0; last_xfer = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_pc(input logic [31:0] a);
        pc_addr  = a;
        pc_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (last_xfer) break;
        end
        check("send_pc_accepted", last_xfer, 1'b1);
        pc_valid = 1'b0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        pc_addr = 32'h0; pc_valid = 1'b0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        instr_ready = 1'b0;
        m_busy = 1'b0; m_acc = 1'b0; m_drain = 1'b0; m_addr = 32'h0; last_xfer = 1'b0;
        auto_mem = 1'b0; mem_pend = 1'b0; mem_wait = 0; mem_dat = 32'h0;
        n_checks = 0; n_pass = 0;
        #2;
        do_reset(2);

        // Basic fetch: response two cycles after the request.
        mem_req_ready = 1'b1;
        pc_addr = 32'h10; pc_valid = 1'b1;
        cycle();
        pc_valid = 1'b0;
        #1;
        check("basic_req_valid", mem_req_valid, 1'b1);
        check("basic_req_addr", mem_req_addr, 32'h10);
        cycle();
        cycle();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678;
        cycle();
        mem_resp_valid = 1'b0;
        #1;
        check("basic_valid", instr_valid, 1'b1);
        check("basic_addr", instr_addr, 32'h10);
        check("basic_data", instr_data, 32'h1234_5678);
        check("basic_err", instr_err, 1'b0);
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;

        // Reset while waiting on memory; the late response must be ignored.
        pc_addr = 32'h10; pc_valid = 1'b1;
        cycle();
        pc_valid = 1'b0;
        cycle();
        cycle();
        do_reset(2);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_DEAD;
        cycle();
        mem_resp_valid = 1'b0;
        cycle();
        #1;
        check("rst_late_instr_valid", instr_valid, 1'b0);
        check("rst_late_pc_ready", pc_ready, 1'b1);
        cycle();

        // Back-pressure: two words queued, third address held.
        auto_mem = 1'b1;
        mem_req_ready = 1'b1; instr_ready = 1'b0;
        send_pc(32'h0);
        send_pc(32'h4);
        pc_addr = 32'h8; pc_valid = 1'b1;
        repeat (10) cycle();
        #1;
        check("bp_pc_ready_low", pc_ready, 1'b0);
        check("bp_head_addr", instr_addr, 32'h0);
        instr_ready = 1'b1;
        cycle();
        check("bp_no_xfer_on_pop", last_xfer, 1'b0);
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_xfer) break;
        end
        check("bp_accept_8", last_xfer, 1'b1);
        pc_valid = 1'b0;
        repeat (8) cycle();
        instr_ready = 1'b1;
        repeat (4) cycle();
        instr_ready = 1'b0;
        auto_mem = 1'b0;
        cycle();

        // Flush while waiting: response three cycles later is dropped.
        mem_req_ready = 1'b1;
        pc_addr = 32'h20; pc_valid = 1'b1;
        cycle();
        pc_valid = 1'b0;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        cycle();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_AAAA;
        cycle();
        mem_resp_valid = 1'b0;
        #1;
        check("flw_pc_ready", pc_ready, 1'b1);
        check("flw_instr_valid", instr_valid, 1'b0);
        cycle();

        // Flush coincident with request acceptance: drain, then fetch 0x40.
        mem_req_ready = 1'b0;
        pc_addr = 32'h30; pc_valid = 1'b1;
        cycle();
        pc_valid = 1'b0;
        cycle();
        mem_req_ready = 1'b1; flush = 1'b1;
        cycle();
        flush = 1'b0; mem_req_ready = 1'b0;
        #1;
        check("drain_pc_ready", pc_ready, 1'b0);
        check("drain_req_valid", mem_req_valid, 1'b0);
        cycle();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_5555;
        cycle();
        mem_resp_valid = 1'b0;
        #1;
        check("drain_instr_valid", instr_valid, 1'b0);
        auto_mem = 1'b1; mem_req_ready = 1'b1;
        send_pc(32'h40);
        repeat (8) cycle();
        #1;
        check("drain_next_valid", instr_valid, 1'b1);
        check("drain_next_addr", instr_addr, 32'h40);
        check("drain_next_err", instr_err, 1'b0);
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;

        // Misaligned fetch bypasses memory.
        send_pc(32'h6);
        #1;
        check("mis_req_valid", mem_req_valid, 1'b0);
        check("mis_valid", instr_valid, 1'b1);
        check("mis_addr", instr_addr, 32'h6);
        check("mis_err", instr_err, 1'b1);
        check("mis_data", instr_data, 32'h0);
        instr_ready = 1'b1;
        cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r;
            if (!pc_valid || last_xfer) begin
                r        = $urandom;
                pc_valid = ($urandom_range(2, 0) != 0);
                pc_addr  = {20'h0, r[11:2], ($urandom_range(7, 0) == 0) ? r[1:0] : 2'b00};
            end
            flush         = ($urandom_range(19, 0) == 0);
            instr_ready   = $urandom_range(1, 0) != 0;
            mem_req_ready = ($urandom_range(2, 0) != 0);
            cycle();
        end
        flush = 1'b0; pc_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
